// File: rtl/sb_leaf_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sb_leaf_stream_fifo
// Description : Leaf-level valid/ready FIFO stage. Buffers up to DEPTH words
//               of DATA_W bits between an upstream producer and a downstream
//               consumer, preserving strict order, and exposes occupancy.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_W  payload width in bits (>=1)
//   DEPTH   storage entries (power of two, >=2)
//   CNT_W   occupancy width, derived from DEPTH; leave at its default
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   s_valid  in   upstream word valid
//   s_ready  out  stage can accept a word this cycle
//   s_data   in   upstream payload
//   m_valid  out  word available downstream
//   m_ready  in   downstream accepts the word this cycle
//   m_data   out  downstream payload (zero when nothing is presented)
//   count    out  words currently stored (0..DEPTH)
// Build option:
//   SB_LEAF_FIFO_BYPASS_EN  when defined, an empty FIFO forwards s_valid /
//                           s_data to m_valid / m_data in the same cycle.
// ============================================================================
module sb_leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_pass;   // word forwarded straight through without being stored
  logic w_push;   // word written into storage
  logic w_pop;    // stored word consumed

  assign w_empty = (r_count == '0);

  // Ready depends only on registered occupancy, never on m_ready.
  assign s_ready = rst_n && (r_count != c_full);

`ifdef SB_LEAF_FIFO_BYPASS_EN
  // Empty FIFO: present the incoming word directly. It is only stored when
  // the consumer cannot take it this cycle.
  assign w_pass  = rst_n && w_empty && s_valid && m_ready;
  assign m_valid = rst_n && (!w_empty || s_valid);
  assign m_data  = !rst_n  ? '0 :
                   !w_empty ? r_mem[r_rd_ptr] :
                   s_valid  ? s_data : '0;
`else
  assign w_pass  = 1'b0;
  assign m_valid = rst_n && !w_empty;
  assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;
`endif

  assign w_push = s_valid && s_ready && !w_pass;
  assign w_pop  = rst_n && !w_empty && m_ready;
  assign count  = r_count;

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sb_leaf_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_leaf_stream_fifo
// Description : Self-checking bench for sb_leaf_stream_fifo (DATA_W=8,
//               DEPTH=4). A reference queue tracks accepted words; every
//               cycle the outputs are compared with the queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_leaf_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  count;

  int n_tests;
  int n_fail;

  logic [DATA_W-1:0] exp_q[$];

  sb_leaf_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model at the falling edge, update
  // the model with the handshakes that the rising edge will perform.
  task automatic step();
    bit                exp_ready;
    bit                exp_valid;
    logic [DATA_W-1:0] exp_data;
    int                mcount;
    @(negedge clk);
    mcount = exp_q.size();
    if (!rst_n) begin
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data",  32'(m_data),  32'd0);
      exp_q.delete();
    end else begin
      exp_ready = (mcount != DEPTH);
`ifdef SB_LEAF_FIFO_BYPASS_EN
      exp_valid = (mcount != 0) || s_valid;
`else
      exp_valid = (mcount != 0);
`endif
      if (!exp_valid)       exp_data = '0;
      else if (mcount != 0) exp_data = exp_q[0];
      else                  exp_data = s_data;
      check("s_ready", 32'(s_ready), 32'(exp_ready));
      check("m_valid", 32'(m_valid), 32'(exp_valid));
      check("m_data",  32'(m_data),  32'(exp_data));
      check("count",   32'(count),   32'(mcount));
      if (s_valid && exp_ready) exp_q.push_back(s_data);
      if (exp_valid && m_ready) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // Reset then idle.
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_count", 32'(count), 32'd0);

    // Single word, held then popped.
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0); step();
    check("a1_data", 32'(m_data), 32'h0000_00A1);
    drive(1'b0, 8'h00, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0); step();

    // Fill to full, then hold an extra word that must be refused.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      step();
    end
    drive(1'b1, 8'h14, 1'b0);
    repeat (2) step();
    check("full_count", 32'(count), 32'd4);
    // Pop while full with s_valid high: only the pop happens.
    drive(1'b1, 8'h14, 1'b1); step();
    check("full_pop_count", 32'(count), 32'd3);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) step();
    drive(1'b0, 8'h00, 1'b0); step();

    // Streaming at occupancy 2 across pointer wrap.
    drive(1'b1, 8'hE0, 1'b0); step();
    drive(1'b1, 8'hE1, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      step();
      check("stream_count", 32'(count), 32'd2);
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (2) step();

    // Reset in the middle of traffic with three words stored.
    drive(1'b1, 8'h30, 1'b0); step();
    drive(1'b1, 8'h31, 1'b0); step();
    drive(1'b1, 8'h32, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    check("post_rst_count", 32'(count), 32'd0);
    drive(1'b0, 8'h00, 1'b1); step();

    // Empty FIFO, word offered with consumer ready (pass-through when enabled).
    drive(1'b1, 8'h5C, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1); step();
    // Empty FIFO, word offered with consumer stalled.
    drive(1'b1, 8'h5D, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1); repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (6) step();
    check("final_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
